// File: rtl/ir_cmd_queue.sv
// IR remote command queue: resynchronises decoded NEC frames, maps key codes to
// snake-game commands (reversal filter, auto-repeat) and buffers them in a 4-deep FIFO.
module ir_cmd_queue #(
    parameter logic [7:0]  KEY_UP     = 8'h18,
    parameter logic [7:0]  KEY_DOWN   = 8'h52,
    parameter logic [7:0]  KEY_LEFT   = 8'h08,
    parameter logic [7:0]  KEY_RIGHT  = 8'h5A,
    parameter logic [7:0]  KEY_PAUSE  = 8'h1C,
    parameter logic [23:0] REPEAT_WIN = 24'd9_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ir_data_en,
    input  logic [7:0] ir_data,
    input  logic       ir_repeat_en,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [1:0] heading,
    output logic       overflow
);

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_PAUSE = 3'd5;

    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // ------------------------------------------------------------------
    // Synchronisers and rising-edge detectors
    // ------------------------------------------------------------------
    logic data_s1_q, data_s2_q, data_s3_q;
    logic data_s1_d, data_s2_d, data_s3_d;
    logic rep_s1_q, rep_s2_q, rep_s3_q;
    logic rep_s1_d, rep_s2_d, rep_s3_d;
    logic data_evt, rep_evt;

    always_comb begin
        data_s1_d = ir_data_en;
        data_s2_d = data_s1_q;
        data_s3_d = data_s2_q;
        rep_s1_d  = ir_repeat_en;
        rep_s2_d  = rep_s1_q;
        rep_s3_d  = rep_s2_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_s1_q <= 1'b0;
            data_s2_q <= 1'b0;
            data_s3_q <= 1'b0;
            rep_s1_q  <= 1'b0;
            rep_s2_q  <= 1'b0;
            rep_s3_q  <= 1'b0;
        end else begin
            data_s1_q <= data_s1_d;
            data_s2_q <= data_s2_d;
            data_s3_q <= data_s3_d;
            rep_s1_q  <= rep_s1_d;
            rep_s2_q  <= rep_s2_d;
            rep_s3_q  <= rep_s3_d;
        end
    end

    assign data_evt = data_s2_q & ~data_s3_q;
    assign rep_evt  = rep_s2_q & ~rep_s3_q;

    // ------------------------------------------------------------------
    // Key code mapping
    // ------------------------------------------------------------------
    logic [2:0] key_cmd;
    logic [2:0] key_cmd_m1;
    logic [1:0] key_dir;

    always_comb begin
        key_cmd = CMD_NONE;
        if (ir_data == KEY_UP) begin
            key_cmd = CMD_UP;
        end else if (ir_data == KEY_DOWN) begin
            key_cmd = CMD_DOWN;
        end else if (ir_data == KEY_LEFT) begin
            key_cmd = CMD_LEFT;
        end else if (ir_data == KEY_RIGHT) begin
            key_cmd = CMD_RIGHT;
        end else if (ir_data == KEY_PAUSE) begin
            key_cmd = CMD_PAUSE;
        end
    end

    // Direction commands 1..4 map onto heading 0..3; flipping bit 0 gives the opposite.
    assign key_cmd_m1 = key_cmd - 3'd1;
    assign key_dir    = key_cmd_m1[1:0];

    // ------------------------------------------------------------------
    // Classification stage
    // ------------------------------------------------------------------
    logic        push_req_q, push_req_d;
    logic [2:0]  push_cmd_q, push_cmd_d;
    logic [1:0]  heading_q, heading_d;
    logic [2:0]  last_cmd_q, last_cmd_d;
    logic [23:0] window_q, window_d;
    logic        last_is_dir;

    assign last_is_dir = (last_cmd_q >= CMD_UP) && (last_cmd_q <= CMD_RIGHT);

    always_comb begin
        push_req_d = 1'b0;
        push_cmd_d = CMD_NONE;
        heading_d  = heading_q;
        last_cmd_d = last_cmd_q;
        window_d   = (window_q != 24'd0) ? (window_q - 24'd1) : 24'd0;

        if (data_evt) begin
            if (key_cmd == CMD_NONE) begin
                last_cmd_d = CMD_NONE;
                window_d   = 24'd0;
            end else if (key_cmd == CMD_PAUSE) begin
                push_req_d = 1'b1;
                push_cmd_d = CMD_PAUSE;
                last_cmd_d = CMD_NONE;
            end else if (key_dir == (heading_q ^ 2'b01)) begin
                last_cmd_d = CMD_NONE;
            end else begin
                push_req_d = 1'b1;
                push_cmd_d = key_cmd;
                heading_d  = key_dir;
                last_cmd_d = key_cmd;
                window_d   = REPEAT_WIN;
            end
        end else if (rep_evt && (window_q != 24'd0) && last_is_dir) begin
            // last_cmd always equals heading here, so no reversal check is needed
            push_req_d = 1'b1;
            push_cmd_d = last_cmd_q;
            window_d   = REPEAT_WIN;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            push_req_q <= 1'b0;
            push_cmd_q <= CMD_NONE;
            heading_q  <= DIR_RIGHT;
            last_cmd_q <= CMD_NONE;
            window_q   <= 24'd0;
        end else begin
            push_req_q <= push_req_d;
            push_cmd_q <= push_cmd_d;
            heading_q  <= heading_d;
            last_cmd_q <= last_cmd_d;
            window_q   <= window_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead command FIFO
    // ------------------------------------------------------------------
    logic [2:0] mem_q [4];
    logic [2:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       overflow_q, overflow_d;
    logic       fifo_full, fifo_valid, pop, wr_en;

    assign fifo_full  = (count_q == 3'd4);
    assign fifo_valid = (count_q != 3'd0);
    assign pop        = fifo_valid & cmd_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts
    assign wr_en      = push_req_q & (~fifo_full | pop);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_req_q & fifo_full & ~pop);

        if (wr_en) begin
            mem_d[wr_ptr_q] = push_cmd_q;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= CMD_NONE;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign cmd_valid = fifo_valid;
    assign cmd       = fifo_valid ? mem_q[rd_ptr_q] : CMD_NONE;
    assign heading   = heading_q;
    assign overflow  = overflow_q;

endmodule
